// File: rtl/fpu_issue_queue.sv
// In-order issue queue between the core offload interface and the FPU model.
// Holds accepted FP instructions until committed (dispatched) or killed (dropped).
module fpu_issue_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned X_ID_WIDTH = 4,
    parameter int unsigned XLEN       = 32
) (
    input  logic                    ck,
    input  logic                    rst_n,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic [31:0]             issue_instr,
    input  logic [X_ID_WIDTH-1:0]   issue_id,
    input  logic [XLEN-1:0]         issue_rs0,
    output logic                    issue_accept,
    input  logic                    commit_valid,
    input  logic [X_ID_WIDTH-1:0]   commit_id,
    input  logic                    commit_kill,
    input  logic                    fpu_full,
    output logic                    fpu_enable,
    output logic [31:0]             fpu_instr,
    output logic [X_ID_WIDTH-1:0]   fpu_id,
    output logic [XLEN-1:0]         fpu_xreg_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [31:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [XLEN-1:0]       rs0;
        logic                  committed;
        logic                  killed;
    } entry_t;

    entry_t                ent_q [DEPTH];
    entry_t                ent_d [DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  fpu_enable_q, fpu_enable_d;
    logic [31:0]           fpu_instr_q, fpu_instr_d;
    logic [X_ID_WIDTH-1:0] fpu_id_q, fpu_id_d;
    logic [XLEN-1:0]       fpu_xreg_q, fpu_xreg_d;

    logic                  push;
    logic                  pop;
    logic                  dispatch;
    logic                  not_empty;
    logic                  match_found;
    logic [PW-1:0]         match_idx;
    logic [PW-1:0]         scan_idx;
    logic                  match_new;
    entry_t                head_e;

    // Opcode decode of the offered instruction; FP load/store only for word width.
    always_comb begin
        issue_accept = 1'b0;
        case (issue_instr[6:0])
            7'b1010011,
            7'b1000011,
            7'b1000111,
            7'b1001011,
            7'b1001111: issue_accept = 1'b1;
            7'b0000111,
            7'b0100111: issue_accept = (issue_instr[14:12] == 3'b010);
            default:    issue_accept = 1'b0;
        endcase
    end

    assign issue_ready = (count_q != CW'(DEPTH));
    assign push        = issue_valid & issue_ready & issue_accept;

    // Oldest-first search for an occupied, still-pending entry with the commit id.
    always_comb begin
        match_found = 1'b0;
        match_idx   = head_q;
        scan_idx    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PW'(k);
            if (!match_found && (CW'(k) < count_q) &&
                (ent_q[scan_idx].id == commit_id) &&
                !ent_q[scan_idx].committed && !ent_q[scan_idx].killed) begin
                match_found = 1'b1;
                match_idx   = scan_idx;
            end
        end
    end

    // The entry being enqueued is the youngest candidate, so it only matches as a fallback.
    assign match_new = commit_valid & ~match_found & push & (issue_id == commit_id);

    assign head_e    = ent_q[head_q];
    assign not_empty = (count_q != '0);
    assign dispatch  = not_empty & head_e.committed & ~head_e.killed & ~fpu_full;
    assign pop       = dispatch | (not_empty & head_e.killed);

    // Next-state for storage, pointers, occupancy and dispatch outputs.
    always_comb begin
        ent_d        = ent_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        fpu_enable_d = dispatch;
        fpu_instr_d  = fpu_instr_q;
        fpu_id_d     = fpu_id_q;
        fpu_xreg_d   = fpu_xreg_q;

        if (commit_valid && match_found) begin
            if (commit_kill) begin
                ent_d[match_idx].killed = 1'b1;
            end else begin
                ent_d[match_idx].committed = 1'b1;
            end
        end

        if (push) begin
            ent_d[tail_q].instr     = issue_instr;
            ent_d[tail_q].id        = issue_id;
            ent_d[tail_q].rs0       = issue_rs0;
            ent_d[tail_q].committed = match_new & ~commit_kill;
            ent_d[tail_q].killed    = match_new & commit_kill;
            tail_d                  = tail_q + PW'(1);
        end

        if (pop) begin
            head_d = head_q + PW'(1);
        end

        if (dispatch) begin
            fpu_instr_d = head_e.instr;
            fpu_id_d    = head_e.id;
            fpu_xreg_d  = head_e.rs0;
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            fpu_enable_q <= 1'b0;
            fpu_instr_q  <= '0;
            fpu_id_q     <= '0;
            fpu_xreg_q   <= '0;
        end else begin
            ent_q        <= ent_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            fpu_enable_q <= fpu_enable_d;
            fpu_instr_q  <= fpu_instr_d;
            fpu_id_q     <= fpu_id_d;
            fpu_xreg_q   <= fpu_xreg_d;
        end
    end

    assign fpu_enable    = fpu_enable_q;
    assign fpu_instr     = fpu_instr_q;
    assign fpu_id        = fpu_id_q;
    assign fpu_xreg_data = fpu_xreg_q;
    assign count         = count_q;

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed bench for fpu_issue_queue: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_fpu_issue_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IDW   = 4;
    localparam int unsigned XLEN  = 32;

    logic            ck = 1'b0;
    logic            rst_n = 1'b0;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [31:0]     issue_instr = '0;
    logic [IDW-1:0]  issue_id = '0;
    logic [XLEN-1:0] issue_rs0 = '0;
    logic            issue_accept;
    logic            commit_valid = 1'b0;
    logic [IDW-1:0]  commit_id = '0;
    logic            commit_kill = 1'b0;
    logic            fpu_full = 1'b0;
    logic            fpu_enable;
    logic [31:0]     fpu_instr;
    logic [IDW-1:0]  fpu_id;
    logic [XLEN-1:0] fpu_xreg_data;
    logic [2:0]      count;

    fpu_issue_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(IDW), .XLEN(XLEN)) dut (
        .ck(ck), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_id(issue_id), .issue_rs0(issue_rs0),
        .issue_accept(issue_accept),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .fpu_full(fpu_full), .fpu_enable(fpu_enable), .fpu_instr(fpu_instr),
        .fpu_id(fpu_id), .fpu_xreg_data(fpu_xreg_data), .count(count)
    );

    always #5 ck = ~ck;

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_fp(input logic [31:0] w);
        case (w[6:0])
            7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: return 1'b1;
            7'b0000111, 7'b0100111: return (w[14:12] == 3'b010);
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: the queue as a list of pending instructions, oldest first.
    typedef struct {
        logic [31:0]     instr;
        logic [IDW-1:0]  id;
        logic [XLEN-1:0] rs0;
        bit              c;
        bit              k;
    } m_ent_t;

    m_ent_t          mq[$];
    bit              m_live = 1'b0;
    logic            m_en;
    logic [31:0]     m_instr;
    logic [IDW-1:0]  m_id;
    logic [XLEN-1:0] m_rs0;
    bit              m_push, m_pop, m_disp;
    int              m_hit;
    m_ent_t          m_new;

    always @(posedge ck) begin
        if (!rst_n) begin
            mq.delete();
            m_en = 1'b0; m_instr = '0; m_id = '0; m_rs0 = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            m_push = issue_valid && (mq.size() < DEPTH) && is_fp(issue_instr);
            m_pop  = 1'b0;
            m_disp = 1'b0;
            if (mq.size() > 0) begin
                if (mq[0].k) m_pop = 1'b1;
                else if (mq[0].c && !fpu_full) begin
                    m_pop = 1'b1; m_disp = 1'b1;
                end
            end
            m_hit = -1;
            if (commit_valid) begin
                foreach (mq[i]) begin
                    if (m_hit < 0 && mq[i].id == commit_id && !mq[i].c && !mq[i].k) m_hit = i;
                end
            end
            m_en = m_disp;
            if (m_disp) begin
                m_instr = mq[0].instr; m_id = mq[0].id; m_rs0 = mq[0].rs0;
            end
            if (m_hit >= 0) begin
                if (commit_kill) mq[m_hit].k = 1'b1;
                else             mq[m_hit].c = 1'b1;
            end
            m_new = '{instr: issue_instr, id: issue_id, rs0: issue_rs0, c: 1'b0, k: 1'b0};
            if (m_push && commit_valid && m_hit < 0 && issue_id == commit_id) begin
                if (commit_kill) m_new.k = 1'b1;
                else             m_new.c = 1'b1;
            end
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back(m_new);
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge ck) begin
        if (m_live) begin
            chk("model count", 32'(count), 32'(mq.size()));
            chk("model issue_ready", 32'(issue_ready), 32'(mq.size() < DEPTH));
            chk("model fpu_enable", 32'(fpu_enable), 32'(m_en));
            chk("model fpu_instr", fpu_instr, m_instr);
            chk("model fpu_id", 32'(fpu_id), 32'(m_id));
            chk("model fpu_xreg_data", fpu_xreg_data, m_rs0);
            if (issue_valid) chk("model issue_accept", 32'(issue_accept), 32'(is_fp(issue_instr)));
        end
    end

    task automatic cyc();
        @(posedge ck);
        #2;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_instr = '0; issue_id = '0; issue_rs0 = '0;
        commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0;
    endtask

    task automatic offer(input logic [31:0] w, input logic [IDW-1:0] id, input logic [XLEN-1:0] rs);
        issue_valid = 1'b1; issue_instr = w; issue_id = id; issue_rs0 = rs;
    endtask

    task automatic commit(input logic [IDW-1:0] id, input logic kill);
        commit_valid = 1'b1; commit_id = id; commit_kill = kill;
    endtask

    initial begin
        idle();
        cyc(); cyc();
        chk("reset count", 32'(count), 32'd0);
        chk("reset issue_ready", 32'(issue_ready), 32'd1);
        chk("reset fpu_enable", 32'(fpu_enable), 32'd0);
        chk("reset fpu_instr", fpu_instr, 32'd0);
        chk("reset fpu_id", 32'(fpu_id), 32'd0);
        rst_n = 1'b1;

        // fadd.s with commit in the same cycle
        offer(32'h0020_8053, 4'd3, 32'h11); commit(4'd3, 1'b0);
        #1 chk("t1 accept", 32'(issue_accept), 32'd1);
        cyc(); idle();
        chk("t1 count", 32'(count), 32'd1);
        cyc();
        chk("t1 fpu_enable", 32'(fpu_enable), 32'd1);
        chk("t1 fpu_id", 32'(fpu_id), 32'd3);
        chk("t1 fpu_instr", fpu_instr, 32'h0020_8053);
        chk("t1 fpu_xreg", fpu_xreg_data, 32'h11);
        chk("t1 count", 32'(count), 32'd0);

        // integer add is handshaken but not enqueued
        offer(32'h0000_0033, 4'd1, 32'h0);
        #1 chk("t2 accept", 32'(issue_accept), 32'd0);
        chk("t2 ready", 32'(issue_ready), 32'd1);
        cyc(); idle();
        chk("t2 count", 32'(count), 32'd0);
        chk("t2 fpu_enable", 32'(fpu_enable), 32'd0);

        // fill, stall a fifth offer, then drain in order
        for (int i = 0; i < 4; i++) begin
            offer(32'h0020_8053 | (32'(i) << 7), 4'(i), 32'(100 + i));
            cyc();
        end
        idle();
        chk("t3 full count", 32'(count), 32'd4);
        chk("t3 full ready", 32'(issue_ready), 32'd0);
        offer(32'h0020_8053, 4'd9, 32'h0);
        cyc(); cyc(); idle();
        chk("t3 stalled count", 32'(count), 32'd4);
        commit(4'd0, 1'b0);
        cyc();
        for (int i = 1; i < 4; i++) begin
            commit(4'(i), 1'b0);
            cyc();
            chk("t3 fpu_enable", 32'(fpu_enable), 32'd1);
            chk("t3 fpu_id", 32'(fpu_id), 32'(i - 1));
            if (i == 1) chk("t3 ready after pop", 32'(issue_ready), 32'd1);
        end
        idle();
        cyc();
        chk("t3 last fpu_id", 32'(fpu_id), 32'd3);
        chk("t3 last xreg", fpu_xreg_data, 32'd103);
        chk("t3 drained count", 32'(count), 32'd0);
        cyc();
        chk("t3 quiet", 32'(fpu_enable), 32'd0);

        // kill 5 then commit 6
        offer(32'h0020_8053, 4'd5, 32'h55); cyc();
        offer(32'h0020_8053, 4'd6, 32'h66); cyc();
        idle(); commit(4'd5, 1'b1); cyc();
        commit(4'd6, 1'b0); cyc(); idle();
        chk("t4 kill no strobe", 32'(fpu_enable), 32'd0);
        chk("t4 kill count", 32'(count), 32'd1);
        cyc();
        chk("t4 fpu_enable", 32'(fpu_enable), 32'd1);
        chk("t4 fpu_id", 32'(fpu_id), 32'd6);

        // fmadd.s held by fpu_full for three cycles
        fpu_full = 1'b1;
        offer(32'h0000_0043, 4'd7, 32'h77); commit(4'd7, 1'b0);
        cyc(); idle();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5 held enable", 32'(fpu_enable), 32'd0);
            chk("t5 held id", 32'(fpu_id), 32'd6);
        end
        fpu_full = 1'b0;
        cyc();
        chk("t5 fpu_enable", 32'(fpu_enable), 32'd1);
        chk("t5 fpu_id", 32'(fpu_id), 32'd7);
        chk("t5 fpu_instr", fpu_instr, 32'h0000_0043);

        // flw accepted, fsd (funct3=011) rejected
        offer(32'h0000_2007, 4'd12, 32'hC); commit(4'd12, 1'b0);
        #1 chk("t6 flw accept", 32'(issue_accept), 32'd1);
        cyc(); idle();
        offer(32'h0000_3027, 4'd13, 32'hD);
        #1 chk("t6 fsd accept", 32'(issue_accept), 32'd0);
        cyc(); idle();
        chk("t6 fpu_id", 32'(fpu_id), 32'd12);
        chk("t6 count", 32'(count), 32'd0);
        cyc();

        // reset discards committed entries
        fpu_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(32'h0020_8053, 4'(8 + i), 32'(i)); commit(4'(8 + i), 1'b0);
            cyc();
        end
        idle();
        chk("t7 count", 32'(count), 32'd3);
        rst_n = 1'b0; fpu_full = 1'b0;
        cyc();
        chk("t7 rst count", 32'(count), 32'd0);
        chk("t7 rst enable", 32'(fpu_enable), 32'd0);
        chk("t7 rst fpu_instr", fpu_instr, 32'd0);
        chk("t7 rst ready", 32'(issue_ready), 32'd1);
        rst_n = 1'b1;
        cyc();
        chk("t7 post enable", 32'(fpu_enable), 32'd0);
        commit(4'd9, 1'b0); cyc(); idle(); cyc();
        chk("t7 stale enable", 32'(fpu_enable), 32'd0);
        chk("t7 stale count", 32'(count), 32'd0);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/fpu_issue_queue.md
# fpu_issue_queue

Front-end buffer between the integer core's coprocessor offload interface and the floating-point unit model. It decodes offered instructions, accepts the floating-point ones, and holds them in an in-order queue together with their id and integer-register operand. Each entry waits for its commit or kill message; committed entries are dispatched to the FPU one per cycle whenever the FPU is not stalled.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- X_ID_WIDTH, 4: instruction id width.
- XLEN, 32: integer operand width.

Ports (clock and reset: one clock; reset is synchronous and active-low):
- ck  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- issue_valid  in  1  core offers an instruction.
- issue_ready  out  1  offer taken this cycle.
- issue_instr  in  32  raw instruction word.
- issue_id  in  X_ID_WIDTH  instruction id.
- issue_rs0  in  XLEN  integer source operand.
- issue_accept  out  1  offered instruction is a floating-point instruction; valid when issue_valid=1.
- commit_valid  in  1  commit message valid.
- commit_id  in  X_ID_WIDTH  id being committed or killed.
- commit_kill  in  1  1 = discard the entry, 0 = commit it.
- fpu_full  in  1  FPU cannot take an instruction this cycle.
- fpu_enable  out  1  dispatch strobe to the FPU.
- fpu_instr  out  32  dispatched instruction.
- fpu_id  out  X_ID_WIDTH  dispatched id.
- fpu_xreg_data  out  XLEN  dispatched integer operand.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- issue_accept is combinational from issue_instr[6:0]; it is 1 for these opcodes:
  - 1010011 (OP-FP).
  - 1000011, 1000111, 1001011, 1001111 (fused multiply-add family).
  - 0000111 and 0100111 (FP load and store), only when funct3 = 010.
- issue_ready = (count != DEPTH). A handshake occurs when issue_valid and issue_ready are both 1.
  - With issue_accept=1, the handshake enqueues {instr, id, rs0, committed=0, killed=0} at the tail.
  - With issue_accept=0, the handshake completes with no enqueue.
- Storage is a circular buffer with head and tail pointers of $clog2(DEPTH) bits; both wrap from DEPTH-1 to 0. count tracks occupancy.
- Commit handling: on commit_valid, the oldest occupied entry with id == commit_id that is neither committed nor killed gets committed=1 (commit_kill=0) or killed=1 (commit_kill=1).
  - If no entry matches, the message is ignored.
  - An entry being enqueued in the same cycle is a match candidate. It is considered youngest.
- Head handling, one action per cycle:
  - Head killed: pop, no dispatch.
  - Head committed and fpu_full=0: pop and dispatch.
  - Head committed and fpu_full=1: hold.
  - Head neither committed nor killed: hold.
  - Queue empty: nothing.
- Dispatch registers fpu_enable=1, fpu_instr, fpu_id, fpu_xreg_data. In a cycle with no dispatch, fpu_enable=0 and the data outputs hold their last value.
- Push and pop in the same cycle leave count unchanged. Push is still refused when count==DEPTH at the start of the cycle (no bypass).

## Timing
- Reset (rst_n=0 at an edge): head=tail=0, count=0, all entries invalid, fpu_enable=0, fpu_instr=0, fpu_id=0, fpu_xreg_data=0.
  - issue_ready reads 1 after reset.
  - issue_accept is combinational and not affected by reset.
- Reset mid-operation discards all entries, committed or not, with no dispatch.
- Latency: an instruction handshaken with a commit in cycle N, into an empty queue with fpu_full=0, becomes head in cycle N+1 and shows fpu_enable=1 in cycle N+2.
- Throughput: one dispatch or one kill-drop per cycle.
- fpu_full is sampled in the cycle before fpu_enable would assert.
- issue_ready depends only on registered count, never on issue_valid.

## Test plan
- Reset then issue 0x00208053 (fadd.s), id=3, with commit id=3 in the same cycle: issue_accept=1; fpu_enable=1 two cycles later with fpu_id=3 and fpu_instr=0x00208053; count returns to 0.
- Issue 0x00000033 (add): issue_ready=1, issue_accept=0, count stays 0, no fpu_enable.
- Issue 4 FP instructions (ids 0-3) with no commits: count=4 and issue_ready=0; a fifth offer stalls. Commit ids 0-3: exactly four dispatches in order 0,1,2,3, with issue_ready back to 1 after the first pop.
- Queue ids 5 and 6, kill 5, commit 6: id 5 dropped in one cycle with no strobe; id 6 dispatched in the next cycle.
- Head committed with fpu_full=1 for 3 cycles: fpu_enable stays 0 and outputs are unchanged; dispatch occurs in the cycle after fpu_full falls.
- Fill 3 entries, commit all, assert rst_n=0 for one edge: count=0, fpu_enable=0, and no dispatch afterwards; a commit for a stale id is ignored.
